// File: rtl/q3_pkg.sv
// Shared definitions for the q3 channel multiplexer: mode encoding, default
// sizing and the select-width helper used by the top and the arbiter.
package q3_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int DEF_DATA_W = 7;
   localparam int DEF_NUM_CH = 4;

   // A 2-channel mux still needs a 1-bit index, so never return zero.
   function automatic int selWidth(input int numCh);
      return (numCh > 2) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/q3_rr_arbiter.sv
// Rotating-priority arbiter: grants the lowest requesting index at or after
// ptr_i, wrapping modulo NUM_CH. Purely combinational.
module q3_rr_arbiter
   import q3_pkg::*;
#(
   parameter  int NUM_CH = DEF_NUM_CH,
   localparam int SEL_W  = selWidth(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [SEL_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [SEL_W-1:0]  grantIdx_o,
   output logic              any_o
);

   // ptr_i is always below NUM_CH, so one conditional subtract is enough.
   function automatic logic [SEL_W-1:0] rotIdx(input logic [SEL_W-1:0] ptr, input int offset);
      int sum;
      sum = int'(ptr) + offset;
      if (sum >= NUM_CH) begin
         sum = sum - NUM_CH;
      end
      return SEL_W'(sum);
   endfunction

   // Scan from the farthest offset back to the pointer so the nearest request wins.
   always_comb begin
      grant_o    = '0;
      grantIdx_o = '0;
      any_o      = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req_i[rotIdx(ptr_i, k)]) begin
            grant_o                   = '0;
            grant_o[rotIdx(ptr_i, k)] = 1'b1;
            grantIdx_o                = rotIdx(ptr_i, k);
            any_o                     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/q3_chan_mux.sv
// Multi-channel valid/ready mux with fixed-select or round-robin selection
// feeding a single full-throughput output register and a transfer counter.
module q3_chan_mux
   import q3_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int NUM_CH = DEF_NUM_CH,
   localparam int SEL_W  = selWidth(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     mode_i,
   input  logic [SEL_W-1:0]         sel_i,
   input  logic [NUM_CH-1:0]        in_valid_i,
   input  logic [NUM_CH*DATA_W-1:0] in_data_i,
   output logic [NUM_CH-1:0]        in_ready_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [SEL_W-1:0]         out_ch_o,
   output logic [7:0]               xfer_cnt_o
);

   logic              outValid_q, outValid_d;
   logic [DATA_W-1:0] outData_q, outData_d;
   logic [SEL_W-1:0]  outCh_q, outCh_d;
   logic [SEL_W-1:0]  rrPtr_q, rrPtr_d;
   logic [7:0]        xferCnt_q, xferCnt_d;

   logic              loadEn;
   logic              inXfer;
   logic              outXfer;
   logic [NUM_CH-1:0] fixedReady;
   logic [NUM_CH-1:0] rrGrant;
   logic [SEL_W-1:0]  rrIdx;
   logic              rrAny;
   logic [NUM_CH-1:0] inReady;
   logic [SEL_W-1:0]  xferIdx;
   logic [DATA_W-1:0] xferData;

   q3_rr_arbiter #(
      .NUM_CH     (NUM_CH)
   ) uArbiter (
      .req_i      (in_valid_i),
      .ptr_i      (rrPtr_q),
      .grant_o    (rrGrant),
      .grantIdx_o (rrIdx),
      .any_o      (rrAny)
   );

   assign loadEn  = !outValid_q || out_ready_i;
   assign outXfer = outValid_q && out_ready_i;

   // Fixed mode decodes sel alone, keeping in_valid out of the in_ready cone;
   // an out-of-range sel matches no channel.
   always_comb begin
      fixedReady = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fixedReady[i] = (sel_i == SEL_W'(i));
      end
   end

   always_comb begin
      inReady = '0;
      if (rst_ni && loadEn) begin
         if (mode_i == MODE_RR) begin
            inReady = rrAny ? rrGrant : '0;
         end else begin
            inReady = fixedReady;
         end
      end
   end

   assign in_ready_o = inReady;
   assign inXfer     = |(inReady & in_valid_i);
   assign xferIdx    = (mode_i == MODE_RR) ? rrIdx : sel_i;

   always_comb begin
      xferData = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (xferIdx == SEL_W'(i)) begin
            xferData = in_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // A new word overrides the drain, which is what gives back-to-back throughput.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outCh_d    = outCh_q;
      rrPtr_d    = rrPtr_q;
      xferCnt_d  = xferCnt_q;
      if (inXfer) begin
         outValid_d = 1'b1;
         outData_d  = xferData;
         outCh_d    = xferIdx;
         if (mode_i == MODE_RR) begin
            rrPtr_d = (rrIdx == SEL_W'(NUM_CH - 1)) ? '0 : rrIdx + SEL_W'(1);
         end
      end else if (outXfer) begin
         outValid_d = 1'b0;
      end
      if (outXfer) begin
         xferCnt_d = xferCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outCh_q    <= '0;
         rrPtr_q    <= '0;
         xferCnt_q  <= '0;
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outCh_q    <= outCh_d;
         rrPtr_q    <= rrPtr_d;
         xferCnt_q  <= xferCnt_d;
      end
   end

   assign out_valid_o = outValid_q;
   assign out_data_o  = outData_q;
   assign out_ch_o    = outCh_q;
   assign xfer_cnt_o  = xferCnt_q;

endmodule

// File: tb/tb_q3_chan_mux.sv
// Self-checking bench for q3_chan_mux: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the mux.
module tb_q3_chan_mux;

   localparam int DW  = 7;
   localparam int NC  = 4;
   localparam int NC5 = 5;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            mode_i;
   logic [1:0]      sel_i;
   logic [NC-1:0]   in_valid_i;
   logic [NC*DW-1:0] in_data_i;
   logic [NC-1:0]   in_ready_o;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [DW-1:0]   out_data_o;
   logic [1:0]      out_ch_o;
   logic [7:0]      xfer_cnt_o;

   logic            mode5;
   logic [2:0]      sel5;
   logic [NC5-1:0]  inValid5;
   logic [NC5*DW-1:0] inData5;
   logic [NC5-1:0]  inReady5;
   logic            outValid5;
   logic            outReady5;
   logic [DW-1:0]   outData5;
   logic [2:0]      outCh5;
   logic [7:0]      xferCnt5;

   int vectors     = 0;
   int miscompares = 0;

   logic            mValid;
   logic [DW-1:0]   mData;
   logic [1:0]      mCh;
   int              mPtr;
   logic [7:0]      mCnt;

   always #5 clk_i = ~clk_i;

   q3_chan_mux #(.DATA_W(DW), .NUM_CH(NC)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .mode_i      (mode_i),
      .sel_i       (sel_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_ch_o    (out_ch_o),
      .xfer_cnt_o  (xfer_cnt_o)
   );

   // Five-channel instance so an out-of-range sel is representable.
   q3_chan_mux #(.DATA_W(DW), .NUM_CH(NC5)) dut5 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .mode_i      (mode5),
      .sel_i       (sel5),
      .in_valid_i  (inValid5),
      .in_data_i   (inData5),
      .in_ready_o  (inReady5),
      .out_valid_o (outValid5),
      .out_ready_i (outReady5),
      .out_data_o  (outData5),
      .out_ch_o    (outCh5),
      .xfer_cnt_o  (xferCnt5)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [NC-1:0] modelReady(input logic mode, input logic [1:0] sel,
                                                input logic [NC-1:0] valid, input logic ordy);
      if (mValid && !ordy) return '0;
      if (mode == 1'b0) return 4'b0001 << sel;
      for (int k = 0; k < NC; k++) begin
         if (valid[(mPtr + k) % NC]) return 4'b0001 << ((mPtr + k) % NC);
      end
      return '0;
   endfunction

   task automatic modelReset();
      mValid = 1'b0;
      mData  = '0;
      mCh    = '0;
      mPtr   = 0;
      mCnt   = '0;
   endtask

   // Called at a falling edge: drive, check in_ready, advance model, check outputs.
   task automatic applyStimulus(input logic mode, input logic [1:0] sel, input logic [NC-1:0] valid,
                                input logic [NC*DW-1:0] data, input logic ordy);
      logic [NC-1:0] expReady;
      int g;
      mode_i      = mode;
      sel_i       = sel;
      in_valid_i  = valid;
      in_data_i   = data;
      out_ready_i = ordy;
      #1;
      expReady = modelReady(mode, sel, valid, ordy);
      checkOutput("in_ready", 32'(in_ready_o), 32'(expReady));
      if (mValid && ordy) mCnt = mCnt + 8'd1;
      g = -1;
      for (int i = 0; i < NC; i++) begin
         if (expReady[i] && valid[i]) g = i;
      end
      if (g >= 0) begin
         mValid = 1'b1;
         mData  = data[g*DW +: DW];
         mCh    = 2'(g);
         if (mode) mPtr = (g + 1) % NC;
      end else if (mValid && ordy) begin
         mValid = 1'b0;
      end
      @(posedge clk_i);
      #1;
      checkOutput("out_valid", 32'(out_valid_o), 32'(mValid));
      checkOutput("out_data", 32'(out_data_o), 32'(mData));
      checkOutput("out_ch", 32'(out_ch_o), 32'(mCh));
      checkOutput("xfer_cnt", 32'(xfer_cnt_o), 32'(mCnt));
      @(negedge clk_i);
   endtask

   // Asserts reset between edges and checks the asynchronous clear before any clock.
   task automatic doReset();
      #2;
      in_valid_i  = '1;
      out_ready_i = 1'b0;
      rst_ni      = 1'b0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
      checkOutput("rst_out_data", 32'(out_data_o), 32'd0);
      checkOutput("rst_out_ch", 32'(out_ch_o), 32'd0);
      checkOutput("rst_xfer_cnt", 32'(xfer_cnt_o), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
      modelReset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni      = 1'b1;
      mode_i      = 1'b0;
      sel_i       = '0;
      in_valid_i  = '0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      mode5       = 1'b0;
      sel5        = '0;
      inValid5    = '0;
      inData5     = '0;
      outReady5   = 1'b1;
      modelReset();
      @(negedge clk_i);
      doReset();

      // Fixed select of channel 2, then drain it.
      applyStimulus(1'b0, 2'd2, 4'b0100, 28'(7'h55) << 14, 1'b1);
      checkOutput("fixed_data", 32'(out_data_o), 32'h55);
      checkOutput("fixed_ch", 32'(out_ch_o), 32'd2);
      checkOutput("fixed_valid", 32'(out_valid_o), 32'd1);
      applyStimulus(1'b0, 2'd2, 4'b0000, '0, 1'b1);
      checkOutput("fixed_cnt", 32'(xfer_cnt_o), 32'd1);

      // Round robin with every channel requesting rotates one word per cycle.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 2'(k), 4'b1111, 28'($urandom), 1'b1);
         checkOutput("rr_seq", 32'(out_ch_o), 32'(k % NC));
      end

      // Stall with 0x2A held, then release into a fresh load.
      applyStimulus(1'b0, 2'd1, 4'b0010, 28'(7'h2A) << 7, 1'b1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'($urandom), 2'($urandom), 4'b1111, 28'($urandom), 1'b0);
         checkOutput("stall_data", 32'(out_data_o), 32'h2A);
      end
      applyStimulus(1'b0, 2'd3, 4'b1000, 28'(7'h11) << 21, 1'b1);
      checkOutput("release_data", 32'(out_data_o), 32'h11);

      // Out-of-range select on the five-channel instance.
      inValid5 = '1;
      inData5  = 35'($urandom);
      for (int s = 5; s < 8; s++) begin
         sel5 = 3'(s);
         #1;
         checkOutput("oor_ready", 32'(inReady5), 32'd0);
         @(posedge clk_i);
         #1;
         checkOutput("oor_valid", 32'(outValid5), 32'd0);
         @(negedge clk_i);
      end
      sel5 = 3'd4;
      #1;
      checkOutput("sel4_ready", 32'(inReady5), 32'h10);
      inValid5 = '0;

      // 256 output transfers wrap the counter.
      doReset();
      for (int k = 0; k < 257; k++) begin
         applyStimulus(1'b1, 2'd0, 4'b1111, 28'($urandom), 1'b1);
      end
      checkOutput("cnt_wrap", 32'(xfer_cnt_o), 32'd0);

      // Reset in the middle of a stall discards the word and restarts arbitration.
      applyStimulus(1'b0, 2'd3, 4'b1000, 28'($urandom), 1'b0);
      applyStimulus(1'b0, 2'd3, 4'b1000, 28'($urandom), 1'b0);
      doReset();
      applyStimulus(1'b1, 2'd0, 4'b1111, 28'($urandom), 1'b1);
      checkOutput("rr_restart", 32'(out_ch_o), 32'd0);

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 28'($urandom),
                       ($urandom_range(3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
